pwm_ugt4: RTL and testbench

Registered 4-bit PWM generator. A free-running period counter feeds an unsigned greater-than compare against an active duty value, and the result is registered to drive the output. Duty and period updates are staged through a load handshake and applied only at a period boundary, so the output never glitches mid-period. It sits directly upstream of the UGT compare stage: it produces the count operand and registers the compare result.

---
 rtl/pwm_ugt4_pkg.sv | 10 +
 rtl/pwm_ugt4_ugt_cmp.sv | 17 +
 rtl/pwm_ugt4.sv | 118 +++++++++++
 tb/tb_pwm_ugt4.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ugt4_pkg.sv
// Shared constants for the 4-bit registered PWM generator.
package pwm_ugt4_pkg;

    localparam int unsigned WIDTH_DEF      = 4;
    localparam int unsigned PERIOD_RST_DEF = 15;
    localparam int unsigned COUNT_RST      = 0;
    localparam int unsigned DUTY_RST       = 0;
    localparam int unsigned STAGE_RST      = 0;

endpackage : pwm_ugt4_pkg

// File: rtl/pwm_ugt4_ugt_cmp.sv
// Unsigned strict greater-than compare: O = (I0 > I1).
module ugt_cmp
    import pwm_ugt4_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             O
);

    // Pure combinational magnitude compare
    always_comb begin
        O = (I0 > I1);
    end

endmodule : ugt_cmp

// File: rtl/pwm_ugt4.sv
// Registered PWM generator with period-boundary staged duty/period updates.
module pwm_ugt4
    import pwm_ugt4_pkg::*;
#(
    parameter int unsigned      WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PERIOD_RST_DEF)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DUTY,
    input  logic [WIDTH-1:0] PERIOD,
    output logic             O,
    output logic             WRAP,
    output logic             ACK,
    output logic             PENDING
);

    logic [WIDTH-1:0] count_q,      count_d;
    logic [WIDTH-1:0] duty_act_q,   duty_act_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] duty_stg_q,   duty_stg_d;
    logic [WIDTH-1:0] period_stg_q, period_stg_d;
    logic             pending_q,    pending_d;
    logic             o_q,          o_d;
    logic             wrap_q,       wrap_d;
    logic             ack_q,        ack_d;

    logic             gt_c;
    logic             wrap_c;

    // Compare active duty against the running count
    ugt_cmp #(
        .WIDTH (WIDTH)
    ) u_ugt_cmp (
        .I0 (duty_act_q),
        .I1 (count_q),
        .O  (gt_c)
    );

    // Wrap cycle: enabled and count has reached the terminal value
    always_comb begin
        wrap_c = EN && (count_q == period_act_q);
    end

    // Next-state: counter, output compare, staging and apply handshake
    always_comb begin
        count_d      = count_q;
        duty_act_d   = duty_act_q;
        period_act_d = period_act_q;
        duty_stg_d   = duty_stg_q;
        period_stg_d = period_stg_q;
        pending_d    = pending_q;
        o_d          = o_q;
        wrap_d       = 1'b0;
        ack_d        = 1'b0;

        if (EN) begin
            o_d     = gt_c;
            wrap_d  = wrap_c;
            count_d = wrap_c ? WIDTH'(COUNT_RST) : count_q + WIDTH'(1);
        end

        if (LOAD) begin
            if (wrap_c) begin
                // Load coincident with the boundary goes straight to active
                duty_act_d   = DUTY;
                period_act_d = PERIOD;
                pending_d    = 1'b0;
                ack_d        = 1'b1;
            end else begin
                duty_stg_d   = DUTY;
                period_stg_d = PERIOD;
                pending_d    = 1'b1;
            end
        end else if (wrap_c && pending_q) begin
            duty_act_d   = duty_stg_q;
            period_act_d = period_stg_q;
            pending_d    = 1'b0;
            ack_d        = 1'b1;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count_q      <= WIDTH'(COUNT_RST);
            duty_act_q   <= WIDTH'(DUTY_RST);
            period_act_q <= PERIOD_RST;
            duty_stg_q   <= WIDTH'(STAGE_RST);
            period_stg_q <= WIDTH'(STAGE_RST);
            pending_q    <= 1'b0;
            o_q          <= 1'b0;
            wrap_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            duty_act_q   <= duty_act_d;
            period_act_q <= period_act_d;
            duty_stg_q   <= duty_stg_d;
            period_stg_q <= period_stg_d;
            pending_q    <= pending_d;
            o_q          <= o_d;
            wrap_q       <= wrap_d;
            ack_q        <= ack_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        O       = o_q;
        WRAP    = wrap_q;
        ACK     = ack_q;
        PENDING = pending_q;
    end

endmodule : pwm_ugt4

// File: tb/tb_pwm_ugt4.sv
// Self-checking bench for pwm_ugt4: directed table, corner sequences, random run.
module tb_pwm_ugt4;

    logic       CLK;
    logic       RESETN;
    logic       EN;
    logic       LOAD;
    logic [3:0] DUTY;
    logic [3:0] PERIOD;
    logic       O;
    logic       WRAP;
    logic       ACK;
    logic       PENDING;

    int total;
    int bad;

    // Reference: position within the period, active and staged settings
    int m_pos, m_duty, m_per, m_sduty, m_sper;
    bit m_pend, m_o, m_wrap, m_ack;

    pwm_ugt4 #(
        .WIDTH      (4),
        .PERIOD_RST (4'd15)
    ) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .EN      (EN),
        .LOAD    (LOAD),
        .DUTY    (DUTY),
        .PERIOD  (PERIOD),
        .O       (O),
        .WRAP    (WRAP),
        .ACK     (ACK),
        .PENDING (PENDING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit       en;
        bit       ld;
        bit [3:0] duty;
        bit [3:0] per;
        int       reps;
        bit       o;
        bit       w;
        bit       a;
        bit       p;
    } vec_t;

    vec_t vecs[17];

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pos = 0; m_duty = 0; m_per = 15; m_sduty = 0; m_sper = 0;
        m_pend = 0; m_o = 0; m_wrap = 0; m_ack = 0;
    endfunction

    // A period is m_per+1 cycles; output is high for the first m_duty of them
    function automatic void model_step(bit en, bit ld, int d, int p);
        int  nxt;
        bit  boundary;
        nxt      = (m_pos + 1) % (m_per + 1);
        boundary = en && (nxt == 0);
        m_wrap   = 0;
        m_ack    = 0;
        if (en) begin
            m_o    = (m_pos < m_duty);
            m_wrap = boundary;
            m_pos  = nxt;
        end
        if (ld && boundary) begin
            m_duty = d; m_per = p; m_pend = 0; m_ack = 1;
        end else if (ld) begin
            m_sduty = d; m_sper = p; m_pend = 1;
        end else if (boundary && m_pend) begin
            m_duty = m_sduty; m_per = m_sper; m_pend = 0; m_ack = 1;
        end
    endfunction

    task automatic tick(input bit en, input bit ld, input int d, input int p);
        EN     = en;
        LOAD   = ld;
        DUTY   = 4'(d);
        PERIOD = 4'(p);
        @(posedge CLK);
        model_step(en, ld, d, p);
        #1;
        check("O",       int'(O),       int'(m_o));
        check("WRAP",    int'(WRAP),    int'(m_wrap));
        check("ACK",     int'(ACK),     int'(m_ack));
        check("PENDING", int'(PENDING), int'(m_pend));
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, ".O"},       int'(O),       0);
        check({tag, ".WRAP"},    int'(WRAP),    0);
        check({tag, ".ACK"},     int'(ACK),     0);
        check({tag, ".PENDING"}, int'(PENDING), 0);
    endtask

    task automatic do_reset();
        EN = 0; LOAD = 0; DUTY = 0; PERIOD = 0;
        RESETN = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    initial begin
        int acks;
        int highs;
        int guard;
        bit seen;

        total = 0;
        bad   = 0;
        EN = 0; LOAD = 0; DUTY = 0; PERIOD = 0;
        RESETN = 1'b0;

        //            en ld du pe reps  o w a p
        vecs[0]  = '{1, 1, 2, 3, 1,   0, 0, 0, 1};
        vecs[1]  = '{1, 0, 0, 0, 14,  0, 0, 0, 1};
        vecs[2]  = '{1, 0, 0, 0, 1,   0, 1, 1, 0};
        vecs[3]  = '{1, 0, 0, 0, 1,   1, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 1,   1, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 1,   0, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 1,   0, 1, 0, 0};
        vecs[7]  = '{0, 1, 5, 3, 1,   0, 0, 0, 1};
        vecs[8]  = '{1, 0, 0, 0, 1,   1, 0, 0, 1};
        vecs[9]  = '{1, 0, 0, 0, 1,   1, 0, 0, 1};
        vecs[10] = '{1, 0, 0, 0, 1,   0, 0, 0, 1};
        vecs[11] = '{1, 0, 0, 0, 1,   0, 1, 1, 0};
        vecs[12] = '{1, 0, 0, 0, 1,   1, 0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 1,   1, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 1,   1, 0, 0, 0};
        vecs[15] = '{1, 1, 0, 0, 1,   1, 1, 1, 0};
        vecs[16] = '{1, 0, 0, 0, 1,   0, 1, 0, 0};

        // Directed table from reset
        do_reset();
        for (int r = 0; r < 17; r++) begin
            for (int k = 0; k < vecs[r].reps; k++)
                tick(vecs[r].en, (k == 0) ? vecs[r].ld : 1'b0, vecs[r].duty, vecs[r].per);
            check($sformatf("vec%0d.O", r),       int'(O),       int'(vecs[r].o));
            check($sformatf("vec%0d.WRAP", r),    int'(WRAP),    int'(vecs[r].w));
            check($sformatf("vec%0d.ACK", r),     int'(ACK),     int'(vecs[r].a));
            check($sformatf("vec%0d.PENDING", r), int'(PENDING), int'(vecs[r].p));
        end

        // Two loads within one period: single ACK, second value wins
        do_reset();
        tick(1, 1, 3, 9);
        tick(1, 1, 6, 9);
        acks  = 0;
        seen  = 0;
        guard = 0;
        while (!seen && guard < 40) begin
            tick(1, 0, 0, 0);
            if (ACK) acks++;
            if (WRAP) seen = 1;
            else check("double_load.PENDING_held", int'(PENDING), 1);
            guard++;
        end
        check("double_load.wrap_seen", int'(seen), 1);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0);
            if (ACK) acks++;
            if (O) highs++;
        end
        check("double_load.ack_count", acks, 1);
        check("double_load.high_cycles", highs, 6);

        // Freeze for 5 cycles with a load during the freeze
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        tick(0, 1, 1, 4);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
        check("freeze.PENDING", int'(PENDING), 1);
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);

        // Asynchronous reset while a load is pending at count 5
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        tick(1, 1, 7, 2);
        check("prereset.PENDING", int'(PENDING), 1);
        #2;
        RESETN = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("midreset");
        @(negedge CLK);
        RESETN = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0, 0);
            if (ACK) acks++;
        end
        check("postreset.ack_count", acks, 1 - 1);

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit ld;
            int d;
            int p;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            d  = int'($urandom_range(0, 15));
            p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
            tick(en, ld, d, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_ugt4
